board_input_cond: RTL and testbench

- Input conditioning stage directly upstream of the Board top level.
- Takes raw push-button and slide-switch levels from the FPGA pins and synchronises them into CLK.
- Debounces each bit independently and produces clean levels plus single-cycle edge pulses.
- Board's KEY and SW inputs, and any MMIO input register the CPU reads, connect to these outputs instead of the raw pins.

---
 rtl/board_input_cond.sv | 145 ++++++++++++++
 tb/tb_board_input_cond.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/board_input_cond.sv
// Input conditioning for the board's push-buttons and slide switches: 2-flop sync, per-bit debounce, edge pulses.
// Optional key auto-repeat is built when the macro AUTO_REPEAT_EN is defined.
module board_input_cond #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] KEY_RAW,
  input  logic [9:0] SW_RAW,
  output logic [1:0] KEY_DB,
  output logic [1:0] KEY_PRESS,
  output logic [1:0] KEY_RELEASE,
  output logic [9:0] SW_DB,
  output logic [9:0] SW_CHG
);

  localparam int               NB       = 12;  // bits [1:0] keys, [11:2] switches
  localparam logic [1:0]       KEY_IDLE = (KEY_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || (DEBOUNCE_CYCLES - 1) >= (1 << CNT_W) ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("board_input_cond: illegal parameter combination");
  end

  logic [1:0]       r_key_s1, r_key_s2;
  logic [9:0]       r_sw_s1, r_sw_s2;
  logic [NB-1:0]    w_sync;
  logic [NB-1:0]    r_stable;
  logic [NB-1:0]    w_accept;
  logic [CNT_W-1:0] r_cnt [NB];
  logic [1:0]       r_key_press, r_key_release;
  logic [9:0]       r_sw_chg;
  logic [1:0]       w_rep_fire;

  // Keys idle at their released pin level so reset never looks like a press.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_key_s1 <= KEY_IDLE;
      r_key_s2 <= KEY_IDLE;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, which is what makes this a real 2-stage chain.
      r_key_s1 <= KEY_RAW;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= SW_RAW;
      r_sw_s2  <= r_sw_s1;
    end
  end

  assign w_sync = {r_sw_s2, (KEY_ACTIVE_LOW != 0) ? ~r_key_s2 : r_key_s2};

  always_comb begin
    // NOTE: default first so no path through the loop leaves a bit unassigned (that would infer a latch).
    w_accept = '0;
    for (int i = 0; i < NB; i++) begin
      w_accept[i] = (w_sync[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_stable <= '0;
      // NOTE: the counter array is a bank of flops, not RAM, so it is reset like any other state.
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (w_sync[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_stable[i] <= w_sync[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Pulses are registered alongside r_stable so they coincide with the level change.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_key_press   <= '0;
      r_key_release <= '0;
      r_sw_chg      <= '0;
    end else begin
      r_key_press   <= (w_accept[1:0] & w_sync[1:0]) | w_rep_fire;
      r_key_release <= w_accept[1:0] & ~w_sync[1:0];
      r_sw_chg      <= w_accept[NB-1:2];
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int               REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int               REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PER = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] r_rep [2];
  logic [1:0]       r_rep_first;

  // No repeat in the release cycle: a pending acceptance on a held key is always a release.
  always_comb begin
    w_rep_fire = '0;
    for (int k = 0; k < 2; k++) begin
      if (r_stable[k] && !w_accept[k]) begin
        w_rep_fire[k] = r_rep_first[k] ? (r_rep[k] == REP_DLY) : (r_rep[k] == REP_PER);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rep_first <= '1;
      for (int k = 0; k < 2; k++) r_rep[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!r_stable[k] || w_accept[k]) begin
          r_rep[k]       <= '0;
          r_rep_first[k] <= 1'b1;
        end else if (w_rep_fire[k]) begin
          r_rep[k]       <= '0;
          r_rep_first[k] <= 1'b0;
        end else begin
          r_rep[k] <= r_rep[k] + 1'b1;
        end
      end
    end
  end
`else
  assign w_rep_fire = '0;
`endif

  assign KEY_DB      = r_stable[1:0];
  assign SW_DB       = r_stable[NB-1:2];
  assign KEY_PRESS   = r_key_press;
  assign KEY_RELEASE = r_key_release;
  assign SW_CHG      = r_sw_chg;

endmodule

// File: tb/tb_board_input_cond.sv
// Self-checking bench for board_input_cond: per-cycle vector table with a scoreboard queue of expected outputs.
// Define AUTO_REPEAT_EN for both bench and RTL to check the key auto-repeat timing.
module tb_board_input_cond;

  localparam int DB  = 4;       // DEBOUNCE_CYCLES
  localparam int LAT = DB + 2;  // edge on which a clean raw change shows on *_DB

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] KEY_RAW;
  logic [9:0] SW_RAW;
  logic [1:0] KEY_DB, KEY_PRESS, KEY_RELEASE;
  logic [9:0] SW_DB, SW_CHG;

  board_input_cond #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (4),
    .KEY_ACTIVE_LOW (1),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .KEY_RAW    (KEY_RAW),
    .SW_RAW     (SW_RAW),
    .KEY_DB     (KEY_DB),
    .KEY_PRESS  (KEY_PRESS),
    .KEY_RELEASE(KEY_RELEASE),
    .SW_DB      (SW_DB),
    .SW_CHG     (SW_CHG)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] key_db;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic [9:0] sw_db;
    logic [9:0] sw_chg;
  } out_t;

  typedef struct {
    logic [1:0] key_raw;
    logic [9:0] sw_raw;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];
  out_t sb[$];
  out_t cur;  // expected debounced levels; pulse fields unused
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic out_t sample();
    return '{KEY_DB, KEY_PRESS, KEY_RELEASE, SW_DB, SW_CHG};
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got db=%b press=%b rel=%b sw_db=%h sw_chg=%h, want db=%b press=%b rel=%b sw_db=%h sw_chg=%h",
               name, act.key_db, act.key_press, act.key_release, act.sw_db, act.sw_chg,
               exp.key_db, exp.key_press, exp.key_release, exp.sw_db, exp.sw_chg);
    end
  endtask

  function automatic out_t levels(input out_t l);
    out_t e = '0;
    e.key_db = l.key_db;
    e.sw_db  = l.sw_db;
    return e;
  endfunction

  function automatic void add(input logic [1:0] key, input logic [9:0] sw, input out_t e);
    vecs.push_back('{key, sw, e});
  endfunction

  // Hold raw inputs for n cycles, starting from settled inputs; any change lands on edge LAT.
  function automatic void add_settle(input logic [1:0] key, input logic [9:0] sw, input int n);
    out_t tgt, e;
    tgt = '0;
    tgt.key_db = ~key;
    tgt.sw_db  = sw;
    for (int i = 1; i <= n; i++) begin
      if (i < LAT) e = levels(cur);
      else         e = levels(tgt);
      if (i == LAT) begin
        e.key_press   = tgt.key_db & ~cur.key_db;
        e.key_release = ~tgt.key_db & cur.key_db;
        e.sw_chg      = tgt.sw_db ^ cur.sw_db;
      end
      add(key, sw, e);
    end
    cur = levels(tgt);
  endfunction

  // Drive each vector, queue its expectation, and compare one cycle later (sampled 1 time unit after the edge).
  task automatic run_vecs(input string name);
    out_t e;
    foreach (vecs[i]) begin
      KEY_RAW = vecs[i].key_raw;
      SW_RAW  = vecs[i].sw_raw;
      sb.push_back(vecs[i].exp);
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      check($sformatf("%s[%0d]", name, i), sample(), e);
    end
    vecs.delete();
  endtask

  initial begin
    out_t e;
    int   press_at[$];
    cur     = '0;
    RST     = 1'b0;
    KEY_RAW = 2'b11;
    SW_RAW  = 10'h000;
    #23;
    check("reset_outputs", sample(), '0);
    @(negedge CLK);
    RST = 1'b1;

    add_settle(2'b11, 10'h000, 20);
    run_vecs("idle_after_reset");

    add_settle(2'b10, 10'h000, 8);
    add_settle(2'b11, 10'h000, 8);
    run_vecs("clean_press_release");

    // Key 1 low for 3 cycles: rejected.
    for (int i = 1; i <= 10; i++) add((i <= 3) ? 2'b01 : 2'b11, 10'h000, levels(cur));
    run_vecs("glitch_3");

    // Key 1 low for exactly 4 cycles: accepted on edge 6, released on edge 10.
    for (int i = 1; i <= 12; i++) begin
      e = '0;
      e.key_db[1]      = (i >= 6 && i <= 9);
      e.key_press[1]   = (i == 6);
      e.key_release[1] = (i == 10);
      add((i <= 4) ? 2'b01 : 2'b11, 10'h000, e);
    end
    run_vecs("glitch_4");

    // SW[5] bounces 1,0,1,0 in pairs, then holds 1 from cycle 9: accepted on edge 14 only.
    for (int i = 1; i <= 16; i++) begin
      e = '0;
      e.sw_db[5]  = (i >= 14);
      e.sw_chg[5] = (i == 14);
      add(2'b11, (i <= 8 && ((i - 1) / 2) % 2 == 1) ? 10'h000 : 10'h020, e);
    end
    run_vecs("bounce");
    cur.sw_db = 10'h020;
    add_settle(2'b11, 10'h000, 8);
    run_vecs("bounce_clear");

    add_settle(2'b11, 10'h3FF, 8);
    add_settle(2'b11, 10'h000, 8);
    run_vecs("all_switches");

    // Change all switches, then reset 3 cycles in: the count must restart after reset.
    for (int i = 1; i <= 3; i++) add(2'b11, 10'h3FF, levels(cur));
    run_vecs("pre_reset");
    RST = 1'b0;
    #2;
    check("mid_reset_outputs", sample(), '0);
    #3;
    RST = 1'b1;
    cur = '0;
    add_settle(2'b11, 10'h3FF, 8);
    add_settle(2'b11, 10'h000, 8);
    run_vecs("after_mid_reset");

    // Key 0 held: press accepted on edge 6, raw released from cycle 61 so KEY_DB falls on edge 66.
`ifdef AUTO_REPEAT_EN
    press_at = '{6, 26, 34, 42, 50, 58};
`else
    press_at = '{6};
`endif
    for (int i = 1; i <= 75; i++) begin
      e = '0;
      e.key_db[0]      = (i >= 6 && i <= 65);
      e.key_release[0] = (i == 66);
      foreach (press_at[j]) if (press_at[j] == i) e.key_press[0] = 1'b1;
      add((i <= 60) ? 2'b10 : 2'b11, 10'h000, e);
    end
    run_vecs("hold_repeat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
